// File: rtl/demux8_frame_capture_pkg.sv
// Shared constants for the 8-channel select-tree mux/demux pair.
// The upstream mux bench and the receive-side demux use the same channel geometry.
package demux8_frame_capture_pkg;

  localparam int N_CH     = 8;
  localparam int SEL_W    = $clog2(N_CH);
  localparam int LAST_IDX = N_CH - 1;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : demux8_frame_capture_pkg

// File: rtl/demux_sel_counter.sv
// Channel select counter: advances on each valid bit, realigns on frame_start,
// and flags the bit that lands on the last channel.
module demux_sel_counter
  import demux8_frame_capture_pkg::*;
#(
  parameter int P_N_CH  = demux8_frame_capture_pkg::N_CH,
  parameter int P_SEL_W = demux8_frame_capture_pkg::SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_realign,
  input  logic               i_advance,
  output logic [P_SEL_W-1:0] o_sl,
  output logic               o_last
);

  localparam logic [P_SEL_W-1:0] LP_LAST = P_SEL_W'(P_N_CH - 1);

  logic [P_SEL_W-1:0] r_sl;
  logic [P_SEL_W-1:0] w_sl_next;

  // A realign with a valid bit consumes channel 0, so the count resumes at 1.
  always_comb begin
    w_sl_next = r_sl;
    if (i_realign) begin
      if (i_advance) begin
        w_sl_next = P_SEL_W'(1);
      end else begin
        w_sl_next = '0;
      end
    end else if (i_advance) begin
      w_sl_next = r_sl + P_SEL_W'(1);
    end else begin
      w_sl_next = r_sl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sl <= '0;
    end else begin
      r_sl <= w_sl_next;
    end
  end

  assign o_sl   = r_sl;
  assign o_last = i_advance & ~i_realign & (r_sl == LP_LAST);

endmodule : demux_sel_counter

// File: rtl/demux8_frame_capture.sv
// Serial-to-parallel receive end of the 8:1 select-tree mux: rebuilds frames
// from the time-multiplexed stream and offers them on a valid/ready handshake.
module demux8_frame_capture
#(
  parameter int N_CH  = demux8_frame_capture_pkg::N_CH,
  parameter int SEL_W = demux8_frame_capture_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [SEL_W-1:0] sl,
  output logic [N_CH-1:0]  y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             overflow,
  input  logic             ovf_clr
);

  import demux8_frame_capture_pkg::*;

  logic [SEL_W-1:0] w_sl;
  logic             w_last;
  logic [N_CH-1:0]  w_shadow_next;
  logic [N_CH-1:0]  w_frame;
  logic             w_ovf_set;

  logic [N_CH-1:0]  r_shadow;
  logic [N_CH-1:0]  r_y;
  logic             r_y_valid;
  logic             r_ovf;

  demux_sel_counter #(
    .P_N_CH  (N_CH),
    .P_SEL_W (SEL_W)
  ) u_sel_counter (
    .clk       (clk),
    .rst       (rst),
    .i_realign (frame_start),
    .i_advance (din_valid),
    .o_sl      (w_sl),
    .o_last    (w_last)
  );

  // Realign clears the upper channels so a dropped partial frame leaves no residue.
  always_comb begin
    w_shadow_next = r_shadow;
    if (frame_start) begin
      w_shadow_next = '0;
      if (din_valid) begin
        w_shadow_next[0] = din;
      end else begin
        w_shadow_next[0] = 1'b0;
      end
    end else if (din_valid) begin
      w_shadow_next[w_sl] = din;
    end else begin
      w_shadow_next = r_shadow;
    end
  end

  assign w_frame   = {din, r_shadow[N_CH-2:0]};
  assign w_ovf_set = w_last & r_y_valid & ~y_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else begin
      r_shadow <= w_shadow_next;
    end
  end

  // A completing frame always wins the output register, consumed or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else if (w_last) begin
      r_y       <= w_frame;
      r_y_valid <= 1'b1;
    end else if (r_y_valid && y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign sl       = w_sl;
  assign y        = r_y;
  assign y_valid  = r_y_valid;
  assign overflow = r_ovf;

endmodule : demux8_frame_capture

// File: tb/tb_demux8_frame_capture.sv
// Randomized and directed bench for demux8_frame_capture against a queue-based
// frame model: bits collect in arrival order and a full set of 8 forms a frame.
module tb_demux8_frame_capture;

  localparam int NC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       frame_start;
  logic [2:0] sl;
  logic [7:0] y;
  logic       y_valid;
  logic       y_ready;
  logic       overflow;
  logic       ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  bit         cur[$];
  logic [7:0] m_y;
  bit         m_valid;
  bit         m_ovf;

  always #5 clk = ~clk;

  demux8_frame_capture dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .sl          (sl),
    .y           (y),
    .y_valid     (y_valid),
    .y_ready     (y_ready),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    m_y     = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // One clock of the abstract model: bits since realign, frames of 8, one-deep output.
  task automatic model_step(input bit fs, input bit v, input bit d, input bit rdy, input bit clr);
    bit         done      = 1'b0;
    bit         was_valid = m_valid;
    logic [7:0] f         = 8'h00;
    if (fs) begin
      cur.delete();
      if (v) cur.push_back(d);
    end else if (v) begin
      cur.push_back(d);
      if (cur.size() == NC) begin
        for (int i = 0; i < NC; i++) f[i] = cur[i];
        cur.delete();
        done = 1'b1;
      end
    end
    if (done && was_valid && !rdy) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (done) begin
      m_y     = f;
      m_valid = 1'b1;
    end else if (was_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    check_eq("sl", {29'd0, sl}, cur.size() % NC);
    check_eq("y_valid", {31'd0, y_valid}, {31'd0, m_valid});
    check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check_eq("y", {24'd0, y}, {24'd0, m_y});
  endtask

  task automatic cyc(input bit fs, input bit v, input bit d, input bit rdy, input bit clr);
    @(negedge clk);
    frame_start = fs;
    din_valid   = v;
    din         = d;
    y_ready     = rdy;
    ovf_clr     = clr;
    model_step(fs, v, d, rdy, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    frame_start = 1'b0;
    din_valid   = 1'b0;
    din         = 1'b0;
    y_ready     = 1'b0;
    ovf_clr     = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rdy_last, input bit rdy_rest, input bit gap);
    for (int i = 0; i < NC; i++) begin
      if (gap) cyc(1'b0, 1'b0, 1'b0, rdy_rest, 1'b0);
      cyc(1'b0, 1'b1, b[i], (i == NC - 1) ? rdy_last : rdy_rest, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] pat;
    int         nvalid;
    rst         = 1'b1;
    frame_start = 1'b0;
    din_valid   = 1'b0;
    din         = 1'b0;
    y_ready     = 1'b0;
    ovf_clr     = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-frame, then a clean frame with the consumer ready
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    send_byte(8'b01001101, 1'b1, 1'b1, 1'b0);
    check_eq("s1_y", {24'd0, y}, 32'h4D);
    check_eq("s1_valid", {31'd0, y_valid}, 32'd1);
    check_eq("s1_sl", {29'd0, sl}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("s1_vdrop", {31'd0, y_valid}, 32'd0);

    // Gapped stream
    send_byte(8'b01001101, 1'b1, 1'b1, 1'b1);
    check_eq("s2_y", {24'd0, y}, 32'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure overflow and clear
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
    check_eq("s3_y", {24'd0, y}, 32'h3C);
    check_eq("s3_ovf", {31'd0, overflow}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("s3_clr", {31'd0, overflow}, 32'd0);
    check_eq("s3_hold", {24'd0, y}, 32'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Accept and complete in the same cycle
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0, 1'b0);
    check_eq("s4_y", {24'd0, y}, 32'hFF);
    check_eq("s4_valid", {31'd0, y_valid}, 32'd1);
    check_eq("s4_ovf", {31'd0, overflow}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Realign after a partial frame
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("s5_y", {24'd0, y}, 32'h01);
    check_eq("s5_sl", {29'd0, sl}, 32'd0);
    check_eq("s5_ovf", {31'd0, overflow}, 32'd0);

    // Lockstep loopback through an upstream mux selected by sl
    pat    = 8'b11010010;
    nvalid = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    while (nvalid < 3 * NC) begin
      if ($urandom_range(0, 2) == 0) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        cyc(1'b0, 1'b1, pat[sl], 1'b1, 1'b0);
        nvalid++;
        if (nvalid % NC == 0) check_eq("s6_loop", {24'd0, y}, {24'd0, pat});
      end
    end

    // Random traffic with occasional realign, clear and reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 7) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_demux8_frame_capture
